// File: rtl/spike_rle_encoder.sv
// Spike-frame run-length encoder: turns one N-bit spike frame into 4-bit SPIKE/SKIP codes
// whose pointer advances sum to N, plus a per-frame spike count.
module spike_rle_encoder #(
    parameter int N = 128,
    localparam int ADDRWID = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       spk_vec,
    input  logic               spk_valid,
    output logic               spk_ready,
    output logic [3:0]         enc,
    output logic               enc_valid,
    input  logic               enc_ready,
    output logic               enc_last,
    output logic [ADDRWID:0]   spk_cnt,
    output logic               cnt_valid
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [ADDRWID:0] N_W = (ADDRWID+1)'(N);

    logic [1:0]       state_reg;
    logic [N-1:0]     frame_reg;
    logic [ADDRWID:0] p_reg;
    logic [ADDRWID:0] cnt_reg;
    logic [3:0]       enc_reg;
    logic             enc_valid_reg;
    logic             enc_last_reg;
    logic [ADDRWID:0] spk_cnt_reg;
    logic             cnt_valid_reg;

    logic             idle;
    logic [N-1:0]     src;
    logic [ADDRWID:0] pos;
    logic [N+6:0]     src_ext;
    logic [7:0]       window;
    logic [ADDRWID:0] rem;
    logic [2:0]       first;
    logic             spike;
    logic [3:0]       adv;
    logic [3:0]       code;
    logic             last;
    logic             take;
    logic [ADDRWID:0] cnt_base;

    // While idle the first code is built straight from the incoming frame so it is
    // registered in the acceptance cycle; afterwards the latched frame is walked.
    assign idle     = (state_reg == S_IDLE);
    assign src      = idle ? spk_vec : frame_reg;
    assign pos      = idle ? '0 : p_reg;
    assign cnt_base = idle ? '0 : cnt_reg;
    assign src_ext  = {7'b0, src};
    assign rem      = N_W - pos;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_window
            assign window[gi] = src_ext[pos + (ADDRWID+1)'(gi)];
        end
    endgenerate

    // Nearest spike strictly after the pointer; bit 0 is handled by the code kind.
    always_comb begin
        first = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (window[i]) first = 3'(i);
        end
    end

    assign spike = window[0];

    always_comb begin
        adv  = 4'd0;
        code = 4'd0;
        if (spike) begin
            if (first != 3'd0)          adv = {1'b0, first};
            else if (rem >= (ADDRWID+1)'(7)) adv = 4'd7;
            else                        adv = rem[3:0];
            code = {1'b0, adv[2:0]};
        end else begin
            if (first != 3'd0)          adv = {1'b0, first};
            else if (rem >= (ADDRWID+1)'(8)) adv = 4'd8;
            else                        adv = rem[3:0];
            code = {1'b1, 3'(adv - 4'd1)};
        end
    end

    assign last = ((ADDRWID+1)'(adv) == rem);
    assign take = (idle && spk_valid) ||
                  (state_reg == S_RUN && (!enc_valid_reg || enc_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            frame_reg     <= '0;
            p_reg         <= '0;
            cnt_reg       <= '0;
            enc_reg       <= 4'd0;
            enc_valid_reg <= 1'b0;
            enc_last_reg  <= 1'b0;
            spk_cnt_reg   <= '0;
            cnt_valid_reg <= 1'b0;
        end else begin
            cnt_valid_reg <= 1'b0;
            if (take) begin
                if (idle) frame_reg <= spk_vec;
                enc_reg       <= code;
                enc_valid_reg <= 1'b1;
                enc_last_reg  <= last;
                p_reg         <= pos + (ADDRWID+1)'(adv);
                cnt_reg       <= cnt_base + (ADDRWID+1)'(spike);
                state_reg     <= last ? S_DRAIN : S_RUN;
            end else if (state_reg == S_DRAIN && enc_ready) begin
                enc_valid_reg <= 1'b0;
                enc_last_reg  <= 1'b0;
                spk_cnt_reg   <= cnt_reg;
                cnt_valid_reg <= 1'b1;
                state_reg     <= S_IDLE;
            end else if (state_reg == 2'd3) begin
                state_reg <= S_IDLE;
            end
        end
    end

    assign spk_ready = idle;
    assign enc       = enc_reg;
    assign enc_valid = enc_valid_reg;
    assign enc_last  = enc_last_reg;
    assign spk_cnt   = spk_cnt_reg;
    assign cnt_valid = cnt_valid_reg;
endmodule

// File: tb/tb_spike_rle_encoder.sv
// Directed bench for spike_rle_encoder with N=16: code sequences, counts, backpressure, reset.
module tb_spike_rle_encoder;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  spk_vec;
    logic          spk_valid;
    logic          spk_ready;
    logic [3:0]    enc;
    logic          enc_valid;
    logic          enc_ready;
    logic          enc_last;
    logic [4:0]    spk_cnt;
    logic          cnt_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] codes [0:31];
    logic       lasts [0:31];
    int         ncodes;
    bit         timeout;
    logic       cnt_valid_seen;
    logic [4:0] cnt_seen;
    logic       pulse_after;
    logic       rdy_at_last;

    spike_rle_encoder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .spk_vec(spk_vec), .spk_valid(spk_valid),
        .spk_ready(spk_ready), .enc(enc), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_last(enc_last), .spk_cnt(spk_cnt), .cnt_valid(cnt_valid)
    );

    always #5 clk = ~clk;

    // Present a frame for one cycle, then scramble spk_vec to show it is not resampled.
    task automatic send_frame(input logic [N-1:0] v);
        @(negedge clk);
        spk_vec   = v;
        spk_valid = 1'b1;
        @(negedge clk);
        spk_valid = 1'b0;
        spk_vec   = ~v;
    endtask

    // Record accepted codes up to enc_last, then the count pulse that follows.
    task automatic collect;
        ncodes  = 0;
        timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (enc_valid && enc_ready && ncodes < 32) begin
                codes[ncodes] = enc;
                lasts[ncodes] = enc_last;
                ncodes++;
                if (enc_last) begin
                    rdy_at_last = spk_ready;
                    timeout = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        if (!timeout) begin
            @(negedge clk);
            cnt_valid_seen = cnt_valid;
            cnt_seen       = spk_cnt;
            @(negedge clk);
            pulse_after    = cnt_valid;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({enc, enc_valid, enc_last, spk_cnt, cnt_valid} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got enc=%h v=%b l=%b cnt=%0d cv=%b, want all 0",
                     enc, enc_valid, enc_last, spk_cnt, cnt_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (spk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, want 1", spk_ready);
        end
    endtask

    task automatic test_two_spikes;
        logic [3:0] e [0:2] = '{4'h3, 4'h7, 4'hD};
        send_frame(16'h0009);
        vectors++;
        if (enc_valid !== 1'b1 || enc !== 4'h3) begin
            miscompares++;
            $display("FAIL two_spikes_latency: got v=%b enc=%h, want v=1 enc=3", enc_valid, enc);
        end
        collect();
        vectors++;
        if (timeout || ncodes != 3) begin
            miscompares++;
            $display("FAIL two_spikes_len: got %0d codes (timeout %b), want 3", ncodes, timeout);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({codes[i], lasts[i]} !== {e[i], 1'(i == 2)}) begin
                miscompares++;
                $display("FAIL two_spikes_code[%0d]: got %h/%b, want %h/%b",
                         i, codes[i], lasts[i], e[i], i == 2);
            end
        end
        vectors++;
        if ({cnt_valid_seen, cnt_seen, pulse_after} !== {1'b1, 5'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL two_spikes_cnt: got cv=%b cnt=%0d next_cv=%b, want 1 2 0",
                     cnt_valid_seen, cnt_seen, pulse_after);
        end
    endtask

    task automatic test_empty;
        send_frame(16'h0000);
        collect();
        vectors++;
        if (timeout || ncodes != 2) begin
            miscompares++;
            $display("FAIL empty_len: got %0d codes (timeout %b), want 2", ncodes, timeout);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({codes[i], lasts[i]} !== {4'hF, 1'(i == 1)}) begin
                miscompares++;
                $display("FAIL empty_code[%0d]: got %h/%b, want f/%b", i, codes[i], lasts[i], i == 1);
            end
        end
        vectors++;
        if ({cnt_valid_seen, cnt_seen} !== {1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL empty_cnt: got cv=%b cnt=%0d, want 1 0", cnt_valid_seen, cnt_seen);
        end
    endtask

    task automatic test_bit15(input string tag);
        logic [3:0] e [0:2] = '{4'hF, 4'hE, 4'h1};
        send_frame(16'h8000);
        collect();
        vectors++;
        if (timeout || ncodes != 3) begin
            miscompares++;
            $display("FAIL %s_len: got %0d codes (timeout %b), want 3", tag, ncodes, timeout);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({codes[i], lasts[i]} !== {e[i], 1'(i == 2)}) begin
                miscompares++;
                $display("FAIL %s_code[%0d]: got %h/%b, want %h/%b",
                         tag, i, codes[i], lasts[i], e[i], i == 2);
            end
        end
        vectors++;
        if ({cnt_valid_seen, cnt_seen} !== {1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL %s_cnt: got cv=%b cnt=%0d, want 1 1", tag, cnt_valid_seen, cnt_seen);
        end
    endtask

    task automatic test_all_ones;
        send_frame(16'hFFFF);
        collect();
        vectors++;
        if (timeout || ncodes != 16) begin
            miscompares++;
            $display("FAIL ones_len: got %0d codes (timeout %b), want 16", ncodes, timeout);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({codes[i], lasts[i]} !== {4'h1, 1'(i == 15)}) begin
                miscompares++;
                $display("FAIL ones_code[%0d]: got %h/%b, want 1/%b", i, codes[i], lasts[i], i == 15);
            end
        end
        vectors++;
        if ({cnt_valid_seen, cnt_seen} !== {1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL ones_cnt: got cv=%b cnt=%0d, want 1 16", cnt_valid_seen, cnt_seen);
        end
    endtask

    task automatic test_backpressure;
        send_frame(16'h0009);
        vectors++;
        if ({enc_valid, enc} !== {1'b1, 4'h3}) begin
            miscompares++;
            $display("FAIL bp_first: got v=%b enc=%h, want 1 3", enc_valid, enc);
        end
        @(negedge clk);
        enc_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({enc_valid, enc, enc_last, spk_ready} !== {1'b1, 4'h7, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b enc=%h l=%b rdy=%b, want 1 7 0 0",
                         c, enc_valid, enc, enc_last, spk_ready);
            end
            if (c < 3) @(negedge clk);
        end
        enc_ready = 1'b1;
        collect();
        vectors++;
        if (timeout || ncodes != 2 || codes[0] !== 4'h7 || codes[1] !== 4'hD || lasts[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_tail: got n=%0d %h %h last=%b, want 2 7 d 1",
                     ncodes, codes[0], codes[1], lasts[1]);
        end
        vectors++;
        if (rdy_at_last !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_at_last: got %b, want 0", rdy_at_last);
        end
        vectors++;
        if ({cnt_valid_seen, cnt_seen} !== {1'b1, 5'd2}) begin
            miscompares++;
            $display("FAIL bp_cnt: got cv=%b cnt=%0d, want 1 2", cnt_valid_seen, cnt_seen);
        end
    endtask

    task automatic test_reset_midframe;
        send_frame(16'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({enc, enc_valid, enc_last, spk_cnt, cnt_valid} !== 12'h000) begin
            miscompares++;
            $display("FAIL midreset_outputs: got enc=%h v=%b l=%b cnt=%0d cv=%b, want all 0",
                     enc, enc_valid, enc_last, spk_cnt, cnt_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (spk_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b, want 1", spk_ready);
        end
        test_bit15("after_reset");
    endtask

    initial begin
        spk_vec   = '0;
        spk_valid = 1'b0;
        enc_ready = 1'b1;
        test_reset();
        test_two_spikes();
        test_empty();
        test_bit15("bit15");
        test_all_ones();
        test_backpressure();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
